// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall controller: load-use, MDU occupancy and memory-wait hazards,
// plus the multiply/divide busy tracker and a free-running stall-cycle counter.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mdu_op,
  input  logic        ex_mdu_div,
  input  logic        ex_use_hilo,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        stall_wb,
  output logic        pc_hold,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_count
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    BUSY
  } mdu_state_e;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_count_q, stall_count_d;

  logic mem_wait, mdu_hazard, load_use;

  always_comb begin
    mem_wait   = mem_req & ~mem_ready;
    mdu_hazard = (state_q == BUSY) & (ex_mdu_op | ex_use_hilo);
    load_use   = ex_is_load & (ex_rt != 5'd0) &
                 ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));
  end

  // Each cause stalls its own stage and everything upstream, so the union of
  // simultaneous causes collapses to the deepest one.
  always_comb begin
    stall_mem = mem_wait;
    stall_ex  = mem_wait | mdu_hazard;
    stall_id  = mem_wait | mdu_hazard | load_use;
    stall_if  = stall_id;
    stall_wb  = 1'b0;
    pc_hold   = stall_if;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdu_done = 1'b0;
    mdu_busy = (state_q == BUSY);
    case (state_q)
      IDLE: begin
        if (ex_mdu_op && !stall_ex) begin
          state_d = BUSY;
          cnt_d   = ex_mdu_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          mdu_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_if) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_use_rs, id_use_rt, ex_is_load, ex_mdu_op, ex_mdu_div, ex_use_hilo;
  logic        mem_req, mem_ready;
  logic        stall_if, stall_id, stall_ex, stall_mem, stall_wb, pc_hold;
  logic        mdu_busy, mdu_done;
  logic [31:0] stall_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        chk_en   = 1'b0;

  // model state: cycles of MDU work left, and the stall-cycle tally
  int unsigned m_left   = 0;
  logic [31:0] m_cnt    = '0;
  int unsigned pre_seq  = 0;
  int unsigned pre_seen = 0;
  logic [31:0] pre_val  = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt), .ex_mdu_op(ex_mdu_op),
    .ex_mdu_div(ex_mdu_div), .ex_use_hilo(ex_use_hilo),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .pc_hold(pc_hold),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_count(stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Number of stages (counted from IF) that must hold: 3 = through MEM,
  // 2 = through EX, 1 = IF and ID, 0 = none.
  function automatic int depth();
    if (mem_req && !mem_ready) return 3;
    if (m_left != 0 && (ex_mdu_op || ex_use_hilo)) return 2;
    if (ex_is_load && ex_rt != 0 &&
        ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt))) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   = 0;
      m_cnt    = '0;
      pre_seen = pre_seq;
    end else begin
      int d;
      d = depth();
      if (pre_seen != pre_seq) begin
        m_cnt    = pre_val;
        pre_seen = pre_seq;
      end
      if (d >= 1) m_cnt = m_cnt + 32'd1;
      if (m_left != 0) m_left = m_left - 1;
      else if (ex_mdu_op && d < 2) m_left = ex_mdu_div ? DIVN : MULN;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      int d;
      d = depth();
      check("stall_if",    {31'd0, stall_if},  {31'd0, d >= 1});
      check("stall_id",    {31'd0, stall_id},  {31'd0, d >= 1});
      check("stall_ex",    {31'd0, stall_ex},  {31'd0, d >= 2});
      check("stall_mem",   {31'd0, stall_mem}, {31'd0, d >= 3});
      check("stall_wb",    {31'd0, stall_wb},  32'd0);
      check("pc_hold",     {31'd0, pc_hold},   {31'd0, d >= 1});
      check("mdu_busy",    {31'd0, mdu_busy},  {31'd0, m_left != 0});
      check("mdu_done",    {31'd0, mdu_done},  {31'd0, m_left == 1});
      check("stall_count", stall_count,        m_cnt);
    end
  end

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_is_load = 1'b0;
    ex_mdu_op = 1'b0; ex_mdu_div = 1'b0; ex_use_hilo = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_at, hilo_stall, stalled, acc_at, mem_n, ex_n, busy_flag;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    @(negedge clk); #3;
    check("rst_count", stall_count, 32'd0);
    check("rst_busy", {31'd0, mdu_busy}, 32'd0);

    // load-use on rs
    @(negedge clk);
    ex_is_load = 1'b1; ex_rt = 5'd8; id_use_rs = 1'b1; id_rs = 5'd8;
    #3;
    check("lu_if", {31'd0, stall_if}, 32'd1);
    check("lu_id", {31'd0, stall_id}, 32'd1);
    check("lu_ex", {31'd0, stall_ex}, 32'd0);
    @(negedge clk); clear_inputs(); #3;
    check("lu_count", stall_count, 32'd1);

    // register 0 never hazards
    @(negedge clk);
    ex_is_load = 1'b1; ex_rt = 5'd0; id_use_rs = 1'b1; id_rs = 5'd0;
    #3;
    check("lu_r0", {31'd0, stall_id}, 32'd0);

    // multiply, then mflo from the second busy cycle on
    @(negedge clk); clear_inputs(); ex_mdu_op = 1'b1;
    @(negedge clk); clear_inputs();
    busy_n = 0; done_at = 0; hilo_stall = 0;
    for (int i = 1; i <= 7; i++) begin
      ex_use_hilo = (i >= 2 && i <= 6);
      #3;
      if (mdu_busy) busy_n++;
      if (mdu_done) done_at = i;
      if (stall_ex) hilo_stall++;
      @(negedge clk);
    end
    clear_inputs();
    check("mul_busy", busy_n, 32'd5);
    check("mul_done", done_at, 32'd5);
    check("mflo_stall", hilo_stall, 32'd4);

    // back-to-back divides
    ex_mdu_op = 1'b1; ex_mdu_div = 1'b1;
    #3;
    check("div1_go", {31'd0, stall_ex}, 32'd0);
    stalled = 0; acc_at = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); #3;
      if (stall_ex) stalled++;
      else begin
        acc_at = i;
        break;
      end
    end
    check("div2_held", stalled, 32'd10);
    check("div2_acc", acc_at, 32'd11);
    @(negedge clk); clear_inputs();
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      #3;
      if (mdu_busy) busy_n++;
      @(negedge clk);
    end
    check("div2_busy", busy_n, 32'd10);

    // 3-cycle memory wait with a load-use and an mdu op underneath
    mem_req = 1'b1; mem_ready = 1'b0;
    ex_is_load = 1'b1; ex_rt = 5'd5; id_use_rt = 1'b1; id_rt = 5'd5;
    ex_mdu_op = 1'b1;
    mem_n = 0; ex_n = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      if (stall_mem && !stall_wb) mem_n++;
      if (stall_ex) ex_n++;
      @(negedge clk);
    end
    clear_inputs(); #3;
    check("mw_mem", mem_n, 32'd3);
    check("mw_ex", ex_n, 32'd3);
    check("mw_noacc", {31'd0, mdu_busy}, 32'd0);

    // reset during divide busy cycle 4
    @(negedge clk); ex_mdu_op = 1'b1; ex_mdu_div = 1'b1;
    @(negedge clk); clear_inputs();
    repeat (3) @(negedge clk);
    #1; rst = 1'b1; #2;
    check("rst_mid_busy", {31'd0, mdu_busy}, 32'd0);
    check("rst_mid_done", {31'd0, mdu_done}, 32'd0);
    check("rst_mid_cnt", stall_count, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); ex_mdu_op = 1'b1;
    @(negedge clk); clear_inputs();
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      #3;
      if (mdu_busy) busy_n++;
      @(negedge clk);
    end
    check("mul_after_rst", busy_n, 32'd5);

    // stall counter wrap
    mem_req = 1'b1; mem_ready = 1'b0;
    #3;
    force dut.stall_count_q = 32'hFFFF_FFFE;
    pre_val = 32'hFFFF_FFFE;
    pre_seq++;
    #1;
    release dut.stall_count_q;
    @(negedge clk); #3;
    check("wrap_max", stall_count, 32'hFFFF_FFFF);
    @(negedge clk); #3;
    check("wrap_zero", stall_count, 32'd0);
    @(negedge clk); clear_inputs();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = ($urandom_range(0, 1) == 1);
      id_use_rt   = ($urandom_range(0, 1) == 1);
      ex_is_load  = ($urandom_range(0, 9) < 3);
      ex_mdu_op   = ($urandom_range(0, 9) < 2);
      ex_mdu_div  = ($urandom_range(0, 1) == 1);
      ex_use_hilo = ($urandom_range(0, 19) < 3);
      mem_req     = ($urandom_range(0, 9) < 3);
      mem_ready   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 499) == 0) begin
        #1; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end
    @(negedge clk); clear_inputs();
    @(negedge clk); #3;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall controller for the five-stage pipeline: it produces the per-stage pause signals consumed by the inter-stage segment registers. It detects load-use hazards, multiply/divide-unit occupancy and memory wait states. Each stage pause drives the upstream-side pause of the register after it and the downstream-side pause of the register before it, so the controller chooses between holding and bubble-inserting in each register. Branches use delay slots, so no flush path exists.

## Interface
- MUL_CYCLES, 5, busy cycles for a multiply (≥1)
- DIV_CYCLES, 10, busy cycles for a divide (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- ex_is_load  in  1  instruction in EX is a load
- ex_rt  in  5  load destination register in EX
- ex_mdu_op  in  1  instruction in EX is mult/multu/div/divu
- ex_mdu_div  in  1  with ex_mdu_op: 1 = divide, 0 = multiply
- ex_use_hilo  in  1  instruction in EX is mfhi/mflo/mthi/mtlo
- mem_req  in  1  MEM stage is performing a data access
- mem_ready  in  1  data memory completes the access this cycle
- stall_if, stall_id, stall_ex, stall_mem, stall_wb  out  1 each  stage pause
- pc_hold  out  1  freeze PC (equals stall_if)
- mdu_busy  out  1  MDU computing
- mdu_done  out  1  one-cycle pulse in the last busy cycle
- stall_count  out  32  cycles with stall_if=1, wraps

## Operation
- Stall outputs are combinational from current inputs and registered MDU state; the segment registers sample them at the same edge.
- Causes, highest priority first:
  - mem_wait = mem_req & ~mem_ready → stall_if..stall_mem = 1; bubble enters WB.
  - mdu_hazard = mdu_busy & (ex_mdu_op | ex_use_hilo) → stall_if..stall_ex = 1; bubble enters MEM.
  - load_use = ex_is_load & ex_rt≠0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)) → stall_if, stall_id = 1; bubble enters EX.
- Resulting stalls are monotone: stall_mem ⇒ stall_ex ⇒ stall_id ⇒ stall_if. stall_wb is constant 0.
- Several simultaneous causes: the stall vector is the union, which equals the highest-priority cause's vector.
- MDU FSM, states IDLE and BUSY, with down-counter cnt of width $clog2(max(MUL_CYCLES, DIV_CYCLES)+1):
  - IDLE: at an edge with ex_mdu_op=1 and stall_ex=0, go to BUSY and load cnt = DIV_CYCLES if ex_mdu_div, else MUL_CYCLES.
  - BUSY: decrement cnt each edge. At cnt==1, mdu_done=1 and the next state is IDLE. mdu_busy = (state==BUSY).
  - A stall or memory wait does not pause the counter.
  - An mdu op reaching EX while BUSY is stalled (mdu_hazard) and accepted on the first edge after return to IDLE.
- stall_count increments at each edge where stall_if=1 and wraps from 2^32−1 to 0.

## Timing
- Reset values: state IDLE, cnt 0, mdu_busy 0, mdu_done 0, stall_count 0. All stall outputs are 0 whenever inputs request nothing.
- Stall response has zero latency, in the same cycle as the cause.
- MDU: op accepted at edge k gives mdu_busy=1 for exactly N cycles after k (N = MUL_CYCLES or DIV_CYCLES). mdu_done is high in the Nth busy cycle; mdu_busy=0 after edge k+N.
- MUL_CYCLES=1: single busy cycle, with mdu_done high in that cycle.
- Load-use lasts one cycle: the bubble makes ex_is_load=0 in the next cycle.
- Reset mid-BUSY: immediate return to IDLE, mdu_busy=0, and no mdu_done pulse.
- ex_rt=0 never causes a load-use stall.

## Test plan
- Load-use: ex_is_load=1, ex_rt=8, id_use_rs=1, id_rs=8 → stall_if=stall_id=1, stall_ex=0 for one cycle; stall_count=1. Repeat with ex_rt=0 → no stall.
- Multiply: ex_mdu_op=1, ex_mdu_div=0 accepted at edge k → mdu_busy high 5 cycles, mdu_done in 5th; mflo arriving in EX at k+2 → stall_if..stall_ex=1 until mdu_busy falls.
- Divide back-to-back: div accepted, second div in EX → held 10 cycles, accepted the cycle after mdu_busy falls, then 10 more busy cycles.
- Memory wait, 3 cycles: mem_req=1, mem_ready=0 → stall_if..stall_mem=1, stall_wb=0 for 3 cycles. Apply a concurrent load-use → vector unchanged; an mdu op in EX during the wait is not accepted.
- Reset asserted mid-divide at busy cycle 4 → mdu_busy=0 immediately, stall_count=0, no mdu_done; a new multiply afterwards gives 5 busy cycles.
- Counter wrap: preload stall_count near 2^32−1 via forced stall cycles (or hierarchical deposit) → wraps to 0.
